// File: rtl/uart_alu_pkg.sv
// -----------------------------------------------------------------------------
// uart_alu_pkg
// Shared definitions for the ALU response frame. The ALU-side framer uses them,
// and so will the host-side frame parser.
//   - State encoding of the framer FSM (IDLE, START, WAIT_BUSY, WAIT_DONE).
//   - Frame length (HEADER, data hi, data lo, flags, checksum).
//   - Default header byte.
// -----------------------------------------------------------------------------
package uart_alu_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    WAIT_BUSY = ST_WAIT_BUSY,
    WAIT_DONE = ST_WAIT_DONE
  } state_t;

  localparam int unsigned FRAME_LEN      = 5;
  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
  localparam logic [2:0]  LAST_IDX       = 3'(FRAME_LEN - 1);

endpackage

// File: rtl/alu_resp_framer.sv
// -----------------------------------------------------------------------------
// alu_resp_framer
// Takes one ALU result (16-bit value + 8-bit flags) over valid/ready and sends
// it to a UART transmitter as a 5-byte frame:
//   HEADER, result[15:8], result[7:0], flags, checksum (XOR of the first four).
// Each byte is paced on the transmitter's busy signal. If busy never rises
// after a start request, the frame is abandoned and frame_err pulses.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   res_data/res_flags    result and flags, captured on accept
//   res_valid/res_ready   input handshake (ready only in IDLE)
//   tx_data/tx_start      byte and one-cycle start request to the transmitter
//   tx_busy               transmitter busy
//   frame_done/frame_err  one-cycle completion / abort pulses
//   busy                  framer is working on a frame
// -----------------------------------------------------------------------------
module alu_resp_framer
  import uart_alu_pkg::*;
#(
  parameter logic [7:0]  HEADER      = HEADER_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] res_data,
  input  logic [7:0]  res_flags,
  input  logic        res_valid,
  output logic        res_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t           state_r, state_s;
  logic [2:0]       idx_r, idx_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [15:0]      data_r, data_s;
  logic [7:0]       flags_r, flags_s;
  logic [7:0]       csum_r, csum_s;
  logic [7:0]       tx_data_r, tx_data_s;
  logic             done_r, done_s;
  logic             err_r, err_s;
  logic             tx_start_s;
  logic [2:0]       idx_next_s;

  // Byte of the frame at position idx.
  function automatic logic [7:0] frame_byte(
    input logic [2:0]  idx,
    input logic [7:0]  hdr,
    input logic [15:0] d,
    input logic [7:0]  f,
    input logic [7:0]  c
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = hdr;
      3'd1:    b = d[15:8];
      3'd2:    b = d[7:0];
      3'd3:    b = f;
      3'd4:    b = c;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Next-state and datapath-next logic of the framer FSM.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r;
    data_s     = data_r;
    flags_s    = flags_r;
    csum_s     = csum_r;
    tx_data_s  = tx_data_r;
    done_s     = 1'b0;
    err_s      = 1'b0;
    tx_start_s = 1'b0;
    cnt_inc_s  = cnt_r + CNT_W'(1);
    idx_next_s = idx_r + 3'd1;

    case (state_r)
      IDLE: begin
        if (res_valid) begin
          data_s    = res_data;
          flags_s   = res_flags;
          csum_s    = HEADER ^ res_data[15:8] ^ res_data[7:0] ^ res_flags;
          idx_s     = 3'd0;
          // The header is loaded now so START can fire in the next cycle.
          tx_data_s = HEADER;
          state_s   = START;
        end else begin
          state_s = IDLE;
        end
      end

      START: begin
        // tx_start depends on tx_busy in this cycle. That keeps accept-to-start
        // at one cycle, and a start is never issued into a busy transmitter.
        if (!tx_busy) begin
          tx_start_s = 1'b1;
          cnt_s      = '0;
          state_s    = WAIT_BUSY;
        end else begin
          state_s = START;
        end
      end

      WAIT_BUSY: begin
        if (tx_busy) begin
          state_s = WAIT_DONE;
        end else if (cnt_inc_s == CNT_LAST) begin
          // No acknowledge from the transmitter: drop the frame, no retry.
          err_s   = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end

      WAIT_DONE: begin
        if (tx_busy) begin
          state_s = WAIT_DONE;
        end else if (idx_r == LAST_IDX) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          idx_s     = idx_next_s;
          tx_data_s = frame_byte(idx_next_s, HEADER, data_r, flags_r, csum_r);
          state_s   = START;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= 3'd0;
      cnt_r     <= '0;
      data_r    <= 16'h0000;
      flags_r   <= 8'h00;
      csum_r    <= 8'h00;
      tx_data_r <= 8'h00;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      cnt_r     <= cnt_s;
      data_r    <= data_s;
      flags_r   <= flags_s;
      csum_r    <= csum_s;
      tx_data_r <= tx_data_s;
      done_r    <= done_s;
      err_r     <= err_s;
    end
  end

  assign res_ready  = (state_r == IDLE);
  assign busy       = (state_r != IDLE);
  assign tx_data    = tx_data_r;
  assign tx_start   = tx_start_s;
  assign frame_done = done_r;
  assign frame_err  = err_r;

endmodule

// File: tb/tb_alu_resp_framer.sv
// -----------------------------------------------------------------------------
// tb_alu_resp_framer
// Directed bench for alu_resp_framer. A small transmitter model raises busy one
// cycle after each start and holds it for a few cycles. The model can also be
// disconnected, or busy can be forced high.
// -----------------------------------------------------------------------------
module tb_alu_resp_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] res_data;
  logic [7:0]  res_flags;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        frame_done;
  logic        frame_err;
  logic        busy;

  logic        model_busy = 1'b0;
  logic        force_busy = 1'b0;
  logic        disconnect = 1'b0;
  logic [7:0]  got[$];

  int total = 0;
  int bad = 0;
  int rdy_bad = 0;
  int start_while_busy = 0;
  logic ready_at_end;

  assign tx_busy = model_busy | force_busy;

  always #5 clk = ~clk;

  alu_resp_framer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res_data   (res_data),
    .res_flags  (res_flags),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Transmitter model: log the byte on a start and raise busy one cycle later.
  always begin
    @(negedge clk);
    if (tx_start === 1'b1) begin
      got.push_back(tx_data);
      if (!disconnect) begin
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (6) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  // Watch for starts issued into a busy transmitter.
  always @(negedge clk) begin
    if (tx_start === 1'b1 && tx_busy === 1'b1) start_while_busy <= start_while_busy + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input int base, input logic [39:0] exp);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] b;
      b = (got.size() > base + k) ? got[base + k] : 8'hxx;
      check_val($sformatf("%s_b%0d", tag, k), {24'h0, b}, {24'h0, exp[39 - 8*k -: 8]});
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [7:0] f, input bit keep);
    int n;
    n = 0;
    while (res_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (res_ready !== 1'b1) check_val("send_ready", 32'd0, 32'd1);
    res_data  = d;
    res_flags = f;
    res_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) res_valid = 1'b0;
  endtask

  task automatic wait_end(input bit scramble, output bit d, output bit e);
    bit seen;
    seen = 1'b0;
    d = 1'b0;
    e = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (scramble) begin
        res_data  = 16'($urandom);
        res_flags = 8'($urandom);
      end
      if (frame_done === 1'b1 || frame_err === 1'b1) begin
        d = frame_done;
        e = frame_err;
        ready_at_end = res_ready;
        seen = 1'b1;
        break;
      end else if (res_ready !== 1'b0) begin
        rdy_bad++;
      end
    end
    if (!seen) check_val("frame_end_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit d, e;
    int starts, t0, t1, n;
    logic done_seen;

    rst_n     = 1'b0;
    res_data  = 16'h0000;
    res_flags = 8'h00;
    res_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_ready",    {31'd0, res_ready},  32'd1);
    check_val("rst_tx_start", {31'd0, tx_start},   32'd0);
    check_val("rst_tx_data",  {24'd0, tx_data},    32'h00);
    check_val("rst_done",     {31'd0, frame_done}, 32'd0);
    check_val("rst_err",      {31'd0, frame_err},  32'd0);
    check_val("rst_busy",     {31'd0, busy},       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame.
    got.delete();
    rdy_bad = 0;
    send(16'h1234, 8'h05, 1'b0);
    wait_end(1'b0, d, e);
    check_val("f1_done", {31'd0, d}, 32'd1);
    check_val("f1_err", {31'd0, e}, 32'd0);
    check_val("f1_ready_at_done", {31'd0, ready_at_end}, 32'd1);
    check_val("f1_ready_low", rdy_bad, 32'd0);
    check_val("f1_len", got.size(), 32'd5);
    check_frame("f1", 0, 40'hA5_12_34_05_86);
    @(negedge clk);
    check_val("f1_done_one_cycle", {31'd0, frame_done}, 32'd0);

    // Back-to-back frames with valid held high.
    got.delete();
    res_data  = 16'h1234;
    res_flags = 8'h05;
    res_valid = 1'b1;
    @(posedge clk);
    #1;
    res_data  = 16'hFFFF;
    res_flags = 8'h00;
    wait_end(1'b0, d, e);
    check_val("b2b_first_done", {31'd0, d}, 32'd1);
    @(negedge clk);
    check_val("b2b_restart_start", {31'd0, tx_start}, 32'd1);
    check_val("b2b_restart_data", {24'd0, tx_data}, 32'hA5);
    res_valid = 1'b0;
    wait_end(1'b0, d, e);
    check_val("b2b_second_done", {31'd0, d}, 32'd1);
    check_val("b2b_len", got.size(), 32'd10);
    check_frame("b2b_a", 0, 40'hA5_12_34_05_86);
    check_frame("b2b_b", 5, 40'hA5_FF_FF_00_A5);

    // Transmitter busy at accept: start must wait for it.
    got.delete();
    force_busy = 1'b1;
    send(16'h1234, 8'h05, 1'b0);
    starts = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_start === 1'b1) starts++;
    end
    check_val("hold_no_start", starts, 32'd0);
    check_val("hold_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 force_busy = 1'b0;
    @(negedge clk);
    check_val("hold_release_start", {31'd0, tx_start}, 32'd1);
    check_val("hold_release_data", {24'd0, tx_data}, 32'hA5);
    wait_end(1'b0, d, e);
    check_val("hold_done", {31'd0, d}, 32'd1);
    check_val("hold_len", got.size(), 32'd5);

    // Transmitter disconnected: one start, then abort after the timeout.
    got.delete();
    disconnect = 1'b1;
    send(16'h1234, 8'h05, 1'b0);
    starts = 0;
    t0 = -1;
    t1 = -1;
    done_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        starts++;
        if (t0 < 0) t0 = i;
      end
      if (frame_err === 1'b1) begin
        t1 = i;
        ready_at_end = res_ready;
        done_seen = frame_done;
        break;
      end
    end
    check_val("to_starts", starts, 32'd1);
    check_val("to_err_seen", {31'd0, (t1 >= 0)}, 32'd1);
    check_val("to_delay", t1 - t0, 32'd16);
    check_val("to_ready", {31'd0, ready_at_end}, 32'd1);
    check_val("to_no_done", {31'd0, done_seen}, 32'd0);
    @(negedge clk);
    check_val("to_err_one_cycle", {31'd0, frame_err}, 32'd0);
    check_val("to_idle", {31'd0, busy}, 32'd0);
    disconnect = 1'b0;

    // Reset asserted while byte 2 is in flight.
    got.delete();
    send(16'h1234, 8'h05, 1'b0);
    n = 0;
    while (!(tx_start === 1'b1 && tx_data === 8'h34) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("mid_reached_b2", {31'd0, (n < 200)}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("mid_rst_ready", {31'd0, res_ready}, 32'd1);
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_val("mid_rst_start", {31'd0, tx_start}, 32'd0);
    check_val("mid_rst_data", {24'd0, tx_data}, 32'h00);
    check_val("mid_rst_done", {31'd0, frame_done}, 32'd0);
    check_val("mid_rst_err", {31'd0, frame_err}, 32'd0);
    starts = 0;
    repeat (3) begin
      @(negedge clk);
      if (frame_done === 1'b1 || frame_err === 1'b1) starts++;
    end
    check_val("mid_rst_no_pulse", starts, 32'd0);
    rst_n = 1'b1;
    got.delete();
    send(16'hC0DE, 8'h7F, 1'b0);
    wait_end(1'b0, d, e);
    check_val("post_rst_done", {31'd0, d}, 32'd1);
    check_frame("post_rst", 0, 40'hA5_C0_DE_7F_C4);

    // Inputs scrambled after accept, valid left high during the frame.
    got.delete();
    send(16'hBEEF, 8'h3C, 1'b1);
    wait_end(1'b1, d, e);
    res_valid = 1'b0;
    check_val("scr_done", {31'd0, d}, 32'd1);
    check_val("scr_len", got.size(), 32'd5);
    check_frame("scr", 0, 40'hA5_BE_EF_3C_C8);
    @(negedge clk);
    check_val("scr_no_extra_accept", {31'd0, busy}, 32'd0);

    check_val("start_while_busy", start_while_busy, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_resp_framer.md
Name: alu_resp_framer

Overview:
- Sits directly upstream of the UART transmitter. Accepts one ALU result (16-bit value plus 8-bit flags) via valid/ready.
- Serialises the result into a fixed 5-byte response frame: HEADER, result[15:8], result[7:0], flags, checksum.
- Drives the transmitter's data/start inputs one byte at a time, pacing each byte on the transmitter's busy signal.

Parameters:
- HEADER, 8'hA5, first byte of every frame.
- ACK_TIMEOUT, 16, cycles allowed for tx_busy to rise after tx_start before the frame is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- res_data  in  16  ALU result, sampled on accept.
- res_flags  in  8  ALU status flags, sampled on accept.
- res_valid  in  1  result available.
- res_ready  out  1  high only in IDLE; accept = res_valid & res_ready.
- tx_data  out  8  byte to the transmitter; stable from the tx_start cycle until tx_busy rises.
- tx_start  out  1  one-cycle start request to the transmitter.
- tx_busy  in  1  transmitter busy. It rises 1 cycle after an accepted start and falls after the stop bit.
- frame_done  out  1  one-cycle pulse after the last byte completes.
- frame_err  out  1  one-cycle pulse on ACK timeout abort.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0) forces these values; deassertion is synchronised by the clock edge:
  - state=IDLE, res_ready=1, tx_start=0, tx_data=8'h00.
  - frame_done=0, frame_err=0, busy=0.
  - byte index=0, timeout counter=0.
- Capture on accept:
  - Register res_data and res_flags.
  - Compute checksum = HEADER ^ data[15:8] ^ data[7:0] ^ flags in the same cycle.
  - Set byte index=0 and go to START.
  - Input changes after accept are ignored.
- Byte mux by index: 0 HEADER, 1 data hi, 2 data lo, 3 flags, 4 checksum.
- States:
  - IDLE: res_ready=1. On accept go to START.
  - START:
    - If tx_busy=0: drive tx_data=byte[index] and tx_start=1 for exactly one cycle, clear the timeout counter, go to WAIT_BUSY.
    - If tx_busy=1 (transmitter still finishing a foreign byte): stay in START with tx_start=0.
  - WAIT_BUSY:
    - tx_start=0. Hold tx_data.
    - If tx_busy=1: go to WAIT_DONE.
    - Otherwise increment the counter. When the counter reaches ACK_TIMEOUT-1 with tx_busy still 0: pulse frame_err and go to IDLE (frame abandoned, no retry).
  - WAIT_DONE:
    - Wait for tx_busy=0.
    - If index==4: pulse frame_done, go to IDLE.
    - Otherwise index++ and go to START.
- Latency and throughput:
  - Accept to first tx_start is exactly 1 cycle when tx_busy=0.
  - Never issues tx_start while tx_busy=1.
  - Never issues two tx_start pulses for the same byte.
- frame_done and frame_err are mutually exclusive. Each is high for exactly one cycle, in the cycle the block re-enters IDLE; res_ready=1 in that same cycle.
- A new frame can be accepted in the cycle after frame_done.
- res_valid high while not IDLE is ignored and does not stall internal state.
- rst_n asserted mid-frame: immediate return to IDLE, partial frame dropped, no done/err pulse.
- Counter width: $clog2(ACK_TIMEOUT)+1. Byte index: 3 bits, never exceeds 4.

Decomposition:
- Shared package uart_alu_pkg holds:
  - localparams for the state encoding: IDLE, START, WAIT_BUSY, WAIT_DONE.
  - FRAME_LEN=5 and the default HEADER value.
- Both of these are reused by the future host-side frame parser.
- No sub-module. The checksum is a single XOR expression inside the framer.

Test Plan:
- Result 0x1234, flags 0x05, with a uart_tx model attached -> serial bytes A5, 12, 34, 05, 86 in order; frame_done pulses once; res_ready low throughout the frame.
- Back-to-back frames (0x1234/0x05, then 0xFFFF/0x00, valid held high) -> second frame is A5, FF, FF, 00, A5; no gap beyond 1 cycle after frame_done.
- tx_busy held high at accept for 20 cycles -> tx_start stays 0 until tx_busy falls, then exactly one pulse with tx_data=A5.
- tx_busy stuck at 0 (transmitter disconnected) -> exactly one tx_start pulse; frame_err pulses 16 cycles later; block is back in IDLE with res_ready=1.
- rst_n pulsed low during byte 2 (0x34) -> all outputs return to reset values asynchronously; no frame_done; next frame starts cleanly with A5.
- res_data/res_flags changed every cycle after accept -> transmitted bytes match the values captured at accept.
